// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto the shared memory_* decoder bus.
// Watchdog completes transactions that never see memory_ready.
//   state   | meaning
//   S_IDLE  | no transaction on the bus
//   S_ISSUE | memory_valid pulse, payload just loaded
//   S_WAIT  | waiting for memory_ready or watchdog expiry
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready,
  output logic        bus_timeout
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t      state;
  logic        pend_i, pend_d;
  logic [31:0] pl_i_addr, pl_d_addr, pl_d_wdata;
  logic [3:0]  pl_d_wstrb;
  logic        owner_i, last_i;
  logic [CW-1:0] cnt;

  logic        busy, own_i, own_d, fire, done;
  logic        acc_i, acc_d, eff_i, eff_d, win_i, launch;
  logic [31:0] nxt_i_addr, nxt_d_addr, nxt_d_wdata;
  logic [3:0]  nxt_d_wstrb;

  assign busy  = (state != S_IDLE);
  assign own_i = busy && owner_i;
  assign own_d = busy && !owner_i;
  assign fire  = (TIMEOUT != 0) && (state == S_WAIT) && (cnt == '0);
  assign done  = busy && (memory_ready || fire);

  assign imem_ready  = own_i && (memory_ready || fire);
  assign dmem_ready  = own_d && (memory_ready || fire);
  assign imem_rdata  = (own_i && memory_ready) ? memory_rdata : '0;
  assign dmem_rdata  = (own_d && memory_ready) ? memory_rdata : '0;
  assign bus_timeout = fire && !memory_ready;

  // A port completing this cycle may already hand in its next request.
  assign acc_i = imem_valid && ((!pend_i && !own_i) || imem_ready);
  assign acc_d = dmem_valid && ((!pend_d && !own_d) || dmem_ready);
  assign eff_i = pend_i || acc_i;
  assign eff_d = pend_d || acc_d;
  assign win_i = eff_i && (!eff_d || !last_i);
  assign launch = (!busy || done) && (eff_i || eff_d);

  assign nxt_i_addr  = acc_i ? imem_addr  : pl_i_addr;
  assign nxt_d_addr  = acc_d ? dmem_addr  : pl_d_addr;
  assign nxt_d_wdata = acc_d ? dmem_wdata : pl_d_wdata;
  assign nxt_d_wstrb = acc_d ? dmem_wstrb : pl_d_wstrb;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      pend_i       <= 1'b0;
      pend_d       <= 1'b0;
      pl_i_addr    <= '0;
      pl_d_addr    <= '0;
      pl_d_wdata   <= '0;
      pl_d_wstrb   <= '0;
      owner_i      <= 1'b0;
      last_i       <= 1'b1;
      cnt          <= '0;
      memory_valid <= 1'b0;
      memory_instr <= 1'b0;
      memory_addr  <= '0;
      memory_wdata <= '0;
      memory_wstrb <= '0;
    end else begin
      if (acc_i) begin
        pend_i    <= 1'b1;
        pl_i_addr <= imem_addr;
      end
      if (acc_d) begin
        pend_d     <= 1'b1;
        pl_d_addr  <= dmem_addr;
        pl_d_wdata <= dmem_wdata;
        pl_d_wstrb <= dmem_wstrb;
      end
      memory_valid <= launch;
      if (launch) begin
        if (win_i) pend_i <= 1'b0;
        else       pend_d <= 1'b0;
        state        <= S_ISSUE;
        owner_i      <= win_i;
        last_i       <= win_i;
        cnt          <= TO_LOAD;
        memory_instr <= win_i;
        memory_addr  <= win_i ? nxt_i_addr : nxt_d_addr;
        memory_wdata <= win_i ? 32'h0 : nxt_d_wdata;
        memory_wstrb <= win_i ? 4'h0 : nxt_d_wstrb;
      end else begin
        case (state)
          S_ISSUE: state <= done ? S_IDLE : S_WAIT;
          S_WAIT: begin
            if (done)           state <= S_IDLE;
            else if (cnt != '0) cnt   <= cnt - CW'(1);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level
// reference model that tracks pending requests, owner and issue cycle.
module tb_mem_arbiter;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid, dmem_valid, memory_ready;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, memory_rdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] imem_rdata, dmem_rdata, memory_addr, memory_wdata;
  logic        imem_ready, dmem_ready, memory_valid, memory_instr, bus_timeout;
  logic [3:0]  memory_wstrb;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: port 0 = instruction, port 1 = data
  bit          m_pend[2];
  logic [31:0] m_paddr[2];
  logic [31:0] m_pwdata;
  logic [3:0]  m_pwstrb;
  bit          m_busy;
  int          m_owner, m_last, m_issue, cyc;
  bit          m_instr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  bit          e_ready[2];
  bit          complete;
  bit          issue_log[$];

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0;
    m_paddr[0] = '0; m_paddr[1] = '0;
    m_pwdata = '0; m_pwstrb = '0;
    m_busy = 0; m_owner = 0; m_last = 0; m_issue = -100;
    m_instr = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
  endtask

  task automatic tick();
    bit timed, acc;
    bit vld[2];
    logic [31:0] e_rdata[2];
    int w;
    @(negedge clk);
    timed = m_busy && (TIMEOUT != 0) && (cyc == m_issue + TIMEOUT + 1) && !memory_ready;
    complete = m_busy && (memory_ready || timed);
    for (int p = 0; p < 2; p++) begin
      e_ready[p] = complete && (m_owner == p);
      e_rdata[p] = (e_ready[p] && memory_ready) ? memory_rdata : 32'h0;
    end
    check("imem_ready", imem_ready, e_ready[0]);
    check("dmem_ready", dmem_ready, e_ready[1]);
    check("imem_rdata", imem_rdata, e_rdata[0]);
    check("dmem_rdata", dmem_rdata, e_rdata[1]);
    check("bus_timeout", bus_timeout, timed);
    check("memory_valid", memory_valid, m_busy && (cyc == m_issue));
    check("memory_instr", memory_instr, m_instr);
    check("memory_addr", memory_addr, m_addr);
    check("memory_wdata", memory_wdata, m_wdata);
    check("memory_wstrb", memory_wstrb, m_wstrb);
    if (memory_valid === 1'b1) issue_log.push_back(memory_instr);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      vld[0] = imem_valid; vld[1] = dmem_valid;
      for (int p = 0; p < 2; p++) begin
        acc = vld[p] && ((!m_pend[p] && !(m_busy && m_owner == p)) || e_ready[p]);
        if (acc) begin
          m_pend[p] = 1;
          m_paddr[p] = (p == 0) ? imem_addr : dmem_addr;
          if (p == 1) begin
            m_pwdata = dmem_wdata;
            m_pwstrb = dmem_wstrb;
          end
        end
      end
      if (complete) m_busy = 0;
      if (!m_busy && (m_pend[0] || m_pend[1])) begin
        if (m_pend[0] && m_pend[1]) w = 1 - m_last;
        else                        w = m_pend[0] ? 0 : 1;
        m_busy = 1; m_owner = w; m_last = w; m_issue = cyc + 1;
        m_pend[w] = 0;
        m_instr = (w == 0);
        m_addr  = m_paddr[w];
        m_wdata = (w == 1) ? m_pwdata : 32'h0;
        m_wstrb = (w == 1) ? m_pwstrb : 4'h0;
      end
    end
    cyc++;
    #1;
    imem_valid = 0; dmem_valid = 0; memory_ready = 0; rst = 1;
  endtask

  initial begin
    rst = 0; imem_valid = 0; dmem_valid = 0; memory_ready = 0;
    imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0; memory_rdata = '0;
    @(posedge clk); #1;
    model_reset(); cyc = 0;
    rst = 0; tick();
    tick();

    // single fetch
    imem_valid = 1; imem_addr = 32'h100; tick();
    check("fetch_valid", memory_valid, 1);
    check("fetch_instr", memory_instr, 1);
    check("fetch_addr", memory_addr, 32'h100);
    tick();
    memory_ready = 1; memory_rdata = 32'h13; #1;
    check("fetch_ready", imem_ready, 1);
    check("fetch_rdata", imem_rdata, 32'h13);
    check("fetch_dready", dmem_ready, 0);
    tick();

    // simultaneous requests after reset: data first
    rst = 0; tick();
    imem_valid = 1; imem_addr = 32'h200;
    dmem_valid = 1; dmem_addr = 32'h8000_0000; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
    tick();
    check("sim_first_instr", memory_instr, 0);
    check("sim_first_addr", memory_addr, 32'h8000_0000);
    check("sim_first_wdata", memory_wdata, 32'hDEAD_BEEF);
    check("sim_first_wstrb", memory_wstrb, 4'hF);
    tick();
    memory_ready = 1; #1;
    check("sim_d_ready", dmem_ready, 1);
    check("sim_d_iready", imem_ready, 0);
    tick();
    check("sim_i_valid", memory_valid, 1);
    check("sim_i_instr", memory_instr, 1);
    check("sim_i_addr", memory_addr, 32'h200);
    memory_ready = 1; #1;
    check("sim_i_ready", imem_ready, 1);
    check("sim_i_dready", dmem_ready, 0);
    tick();

    // alternation under continuous load
    issue_log.delete();
    for (int i = 0; i < 24; i++) begin
      imem_valid = 1; imem_addr = $urandom;
      dmem_valid = 1; dmem_addr = $urandom; dmem_wdata = $urandom; dmem_wstrb = 4'($urandom);
      memory_ready = 1'($urandom_range(0, 1)); memory_rdata = $urandom;
      tick();
    end
    check("alt_count", 32'(issue_log.size() >= 4), 1);
    if (issue_log.size() > 0) check("alt_first_data", issue_log[0], 0);
    for (int i = 1; i < issue_log.size(); i++)
      check("alt_order", issue_log[i], !issue_log[i-1]);
    for (int i = 0; i < 4; i++) begin memory_ready = 1; tick(); end

    // watchdog timeout
    dmem_valid = 1; dmem_addr = 32'h0; dmem_wstrb = 4'h0; memory_rdata = 32'hA5A5_5A5A;
    tick();
    for (int i = 0; i < 5; i++) tick();
    #1;
    check("to_ready", dmem_ready, 1);
    check("to_rdata", dmem_rdata, 0);
    check("to_flag", bus_timeout, 1);
    tick();
    tick();
    memory_ready = 1; #1;
    check("to_late_d", dmem_ready, 0);
    check("to_late_i", imem_ready, 0);
    tick();

    // reset while waiting
    imem_valid = 1; imem_addr = 32'h300; tick();
    tick();
    rst = 0; tick();
    check("rst_valid", memory_valid, 0);
    check("rst_instr", memory_instr, 0);
    check("rst_addr", memory_addr, 0);
    check("rst_wdata", memory_wdata, 0);
    check("rst_wstrb", memory_wstrb, 0);
    memory_ready = 1; memory_rdata = 32'h1234; #1;
    check("rst_late_i", imem_ready, 0);
    check("rst_late_irdata", imem_rdata, 0);
    tick();
    dmem_valid = 1; dmem_addr = 32'h400; dmem_wdata = 32'h55; dmem_wstrb = 4'h3; tick();
    check("rst_fresh_valid", memory_valid, 1);
    check("rst_fresh_addr", memory_addr, 32'h400);
    memory_ready = 1; tick();

    // protocol edges: drop while in flight, accept alongside ready
    issue_log.delete();
    dmem_valid = 1; dmem_addr = 32'h40; dmem_wstrb = 4'h0; tick();
    dmem_valid = 1; dmem_addr = 32'h44; tick();
    dmem_valid = 1; dmem_addr = 32'h48; tick();
    dmem_valid = 1; dmem_addr = 32'h4C; memory_ready = 1; tick();
    check("edge_reissue", memory_valid, 1);
    check("edge_addr", memory_addr, 32'h4C);
    memory_ready = 1; tick();
    tick();
    check("edge_issues", issue_log.size(), 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      imem_valid = ($urandom_range(0, 3) == 0); imem_addr = $urandom;
      dmem_valid = ($urandom_range(0, 3) == 0); dmem_addr = $urandom;
      dmem_wdata = $urandom; dmem_wstrb = 4'($urandom);
      memory_ready = ($urandom_range(0, 2) == 0); memory_rdata = $urandom;
      if ($urandom_range(0, 249) == 0) rst = 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
